// File: rtl/legv8_control_unit.sv
// LEGv8 multi-cycle control unit: sequences FETCH -> DECODE -> EXECUTE,
// builds the 34-bit datapath ControlWord and registers the immediate/offset.
module legv8_control_unit #(
    parameter logic [4:0] FS_AND   = 5'b00000,
    parameter logic [4:0] FS_ORR   = 5'b00100,
    parameter logic [4:0] FS_ADD   = 5'b01000,
    parameter logic [4:0] FS_SUB   = 5'b01001,
    parameter logic [4:0] FS_PASSB = 5'b11100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [3:0]  status,
    input  logic [3:0]  alu_status,
    output logic [33:0] ControlWord,
    output logic [63:0] constant,
    output logic [1:0]  state,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_DECODE  = 2'b01,
        S_EXECUTE = 2'b10,
        S_HALT    = 2'b11
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
        OP_LDUR, OP_STUR, OP_B, OP_CBZ, OP_CBNZ, OP_BCOND
    } op_t;

    state_t cur_state, nxt_state;
    op_t    op;

    logic [4:0] rd, rn, rm;
    assign rd = IR[4:0];
    assign rn = IR[9:5];
    assign rm = IR[20:16];

    // Carry flag and upper live ALU flags play no part in any decision here.
    logic unused_flags;
    assign unused_flags = ^{status[2], alu_status[3:1]};

    // ControlWord fields
    logic       as_sel, bsel, il, sl, c0, mw, rw;
    logic [1:0] ds, ps, size;
    logic [4:0] fs, da, sa, sb;

    // Constant staging: value computed from IR, loaded only in DECODE
    logic signed [63:0] k_nxt;
    logic               k_load;

    // B.cond evaluation on the registered flags; undefined codes fall through as not taken
    function automatic logic cond_taken(input logic [3:0] cond, input logic v,
                                        input logic n, input logic z);
        case (cond)
            4'b0000: cond_taken = z;
            4'b0001: cond_taken = !z;
            4'b1010: cond_taken = (n == v);
            4'b1011: cond_taken = (n != v);
            4'b1100: cond_taken = !z && (n == v);
            4'b1101: cond_taken = z || (n != v);
            4'b1110: cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase
    endfunction

    // Classify the instruction by its opcode field
    always_comb begin
        op = OP_NONE;
        if      (IR[31:21] == 11'b10001011000) op = OP_ADD;
        else if (IR[31:21] == 11'b11001011000) op = OP_SUB;
        else if (IR[31:21] == 11'b10001010000) op = OP_AND;
        else if (IR[31:21] == 11'b10101010000) op = OP_ORR;
        else if (IR[31:22] == 10'b1001000100)  op = OP_ADDI;
        else if (IR[31:22] == 10'b1101000100)  op = OP_SUBI;
        else if (IR[31:21] == 11'b11111000010) op = OP_LDUR;
        else if (IR[31:21] == 11'b11111000000) op = OP_STUR;
        else if (IR[31:26] == 6'b000101)       op = OP_B;
        else if (IR[31:24] == 8'b10110100)     op = OP_CBZ;
        else if (IR[31:24] == 8'b10110101)     op = OP_CBNZ;
        else if (IR[31:24] == 8'b01010100)     op = OP_BCOND;
    end

    // Immediate extraction; branch offsets subtract 4 because FETCH already advanced the PC
    always_comb begin
        k_nxt  = '0;
        k_load = 1'b1;
        case (op)
            OP_ADDI, OP_SUBI: k_nxt = {52'd0, IR[21:10]};
            OP_LDUR, OP_STUR: k_nxt = {{55{IR[20]}}, IR[20:12]};
            OP_B:             k_nxt = $signed({{36{IR[25]}}, IR[25:0], 2'b00}) - 64'sd4;
            OP_CBZ, OP_CBNZ, OP_BCOND:
                              k_nxt = $signed({{43{IR[23]}}, IR[23:5], 2'b00}) - 64'sd4;
            default:          k_load = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    // Constant register, captured at the end of DECODE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                constant <= '0;
        else if (cur_state == S_DECODE && k_load)  constant <= k_nxt;
    end

    // Next-state sequencing; unsupported opcodes park the unit in HALT
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH:   nxt_state = S_DECODE;
            S_DECODE:  nxt_state = (op == OP_NONE) ? S_HALT : S_EXECUTE;
            S_EXECUTE: nxt_state = S_FETCH;
            default:   nxt_state = S_HALT;
        endcase
    end

    // Control word generation; everything is forced low while reset is held
    always_comb begin
        as_sel = 1'b0; ds = 2'b00; ps = 2'b00; bsel = 1'b0; il = 1'b0; sl = 1'b0;
        fs = 5'd0; c0 = 1'b0; size = 2'b00; mw = 1'b0; rw = 1'b0;
        da = 5'd0; sa = 5'd0; sb = 5'd0;
        if (reset) begin
            case (cur_state)
                S_FETCH: begin
                    as_sel = 1'b1; ds = 2'b11; size = 2'b11; il = 1'b1; ps = 2'b01;
                end
                S_EXECUTE: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI: begin
                            da = rd; sa = rn; sb = rm; sl = 1'b1;
                            rw = (rd != 5'd31);
                            bsel = (op == OP_ADDI) || (op == OP_SUBI);
                            case (op)
                                OP_SUB, OP_SUBI: begin fs = FS_SUB; c0 = 1'b1; end
                                OP_AND:          fs = FS_AND;
                                OP_ORR:          fs = FS_ORR;
                                default:         fs = FS_ADD;
                            endcase
                        end
                        OP_LDUR: begin
                            sa = rn; bsel = 1'b1; fs = FS_ADD; ds = 2'b11; size = 2'b11;
                            da = rd; rw = (rd != 5'd31);
                        end
                        OP_STUR: begin
                            sa = rn; bsel = 1'b1; fs = FS_ADD; sb = rd; ds = 2'b01;
                            size = 2'b11; mw = 1'b1;
                        end
                        OP_B:     ps = 2'b10;
                        OP_CBZ, OP_CBNZ: begin
                            sb = rd; fs = FS_PASSB;
                            ps = (alu_status[0] == (op == OP_CBZ)) ? 2'b10 : 2'b00;
                        end
                        OP_BCOND: ps = cond_taken(IR[3:0], status[3], status[1], status[0])
                                       ? 2'b10 : 2'b00;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign ControlWord = {as_sel, ds, ps, 1'b0, bsel, il, sl, fs, c0, size, mw, rw, da, sa, sb};
    assign state       = cur_state;
    assign halted      = (cur_state == S_HALT);

endmodule
